keccak_arbiter: RTL and testbench

//   Shares one H_function_top Keccak core among N_REQ requesters (SampleInBall_FSM,

---
 rtl/keccak_arb_pkg.sv | 15 +
 rtl/keccak_arbiter_rr_pick.sv | 36 +++
 rtl/keccak_arbiter.sv | 169 ++++++++++++++++
 tb/tb_keccak_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_arb_pkg.sv
// Shared definitions for the Keccak core arbiter.
//   KECCAK_W    : width of the Keccak-f[1600] state
//   arb_state_t : arbiter FSM state encoding
package keccak_arb_pkg;

  localparam int KECCAK_W = 1600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request bit found when scanning
// upward from ptr, wrapping around past N_REQ-1.
// Ports:
//   req    in   N_REQ   request vector
//   ptr    in   IDX_W   index with highest priority this cycle
//   onehot out  N_REQ   one-hot of the chosen requester (0 if none)
//   idx    out  IDX_W   index of the chosen requester (0 if none)
//   any    out  1       at least one request present
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one Keccak core among N_REQ requesters. A requester is granted a whole
// session (round-robin); the core is held in reset for RST_CYCLES at session
// start, then the owner may issue any number of permutations. Core results are
// latched into result_o and signalled only to the owner via done_o.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_i          per-requester session request (level)
//   start_i        per-requester permutation start pulse
//   data_i         per-requester state, requester i at [i*DATA_W +: DATA_W]
//   grant_o        one-hot session owner
//   done_o         one-cycle completion pulse to the owner
//   result_o       latched core output
//   busy_o         arbiter not idle
//   keccak_rst_n   core reset (active-low)
//   start_keccak   core start pulse
//   keccak_in      core input state
//   keccak_output  core result
//   done_keccak    core completion pulse
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no owner; waiting for any request
// ST_CLR   | owner chosen; core held in reset for RST_CYCLES cycles
// ST_READY | core idle; waiting for owner start or owner release
// ST_RUN   | permutation in flight; waiting for done_keccak
module keccak_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = KECCAK_W,
  parameter int RST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        start_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]       result_o,
  output logic                    busy_o,
  output logic                    keccak_rst_n,
  output logic                    start_keccak,
  output logic [DATA_W-1:0]       keccak_in,
  input  logic [DATA_W-1:0]       keccak_output,
  input  logic                    done_keccak
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_d, done_d;
  logic             start_d, krst_d;
  logic             ld_in, ld_res;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             owner_req, owner_start;
  logic [IDX_W-1:0] ptr_after_owner;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_req       = req_i[owner_q];
  assign owner_start     = start_i[owner_q];
  assign ptr_after_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  assign busy_o          = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_o;
    done_d   = '0;
    start_d  = 1'b0;
    ld_in    = 1'b0;
    ld_res   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          grant_d = pick_onehot;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        // Release wins over a start in the same cycle.
        if (!owner_req) begin
          grant_d  = '0;
          rr_ptr_d = ptr_after_owner;
          state_d  = ST_IDLE;
        end else if (owner_start) begin
          ld_in   = 1'b1;
          start_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done_keccak) begin
          // The result is always latched; only a still-present owner is told.
          ld_res = 1'b1;
          if (owner_req) begin
            done_d  = grant_o;
            state_d = ST_READY;
          end else begin
            grant_d  = '0;
            rr_ptr_d = ptr_after_owner;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Core reset is low exactly while the FSM sits in CLR.
    krst_d = (state_d != ST_CLR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      grant_o      <= '0;
      done_o       <= '0;
      start_keccak <= 1'b0;
      keccak_rst_n <= 1'b0;
      keccak_in    <= '0;
      result_o     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      grant_o      <= grant_d;
      done_o       <= done_d;
      start_keccak <= start_d;
      keccak_rst_n <= krst_d;
      if (ld_in)  keccak_in <= data_i[owner_q*DATA_W +: DATA_W];
      if (ld_res) result_o  <= keccak_output;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a session-level reference model.
module tb_keccak_arbiter;

  localparam int N_REQ      = 3;
  localparam int DATA_W     = 1600;
  localparam int RST_CYCLES = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req, start;
  logic [N_REQ*DATA_W-1:0] din;
  logic [DATA_W-1:0]       kout;
  logic                    kdone;
  logic [N_REQ-1:0]        grant, done;
  logic [DATA_W-1:0]       result, kin;
  logic                    busy, krst_n, kstart;

  int n_tests, n_fail;

  // reference model: session owner (-1 = none), remaining core-reset cycles,
  // permutation in flight, round-robin start index, expected registered outputs
  int                m_owner, m_clr_left, m_ptr;
  bit                m_running;
  logic [N_REQ-1:0]  e_grant, e_done;
  logic [DATA_W-1:0] e_result, e_kin;
  logic              e_rst_n, e_start;

  always #5 clk = ~clk;

  keccak_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .start_i       (start),
    .data_i        (din),
    .grant_o       (grant),
    .done_o        (done),
    .result_o      (result),
    .busy_o        (busy),
    .keccak_rst_n  (krst_n),
    .start_keccak  (kstart),
    .keccak_in     (kin),
    .keccak_output (kout),
    .done_keccak   (kdone)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic int first_from(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_clr_left = 0;
    m_running  = 1'b0;
    m_ptr      = 0;
    e_grant    = '0;
    e_done     = '0;
    e_result   = '0;
    e_kin      = '0;
    e_rst_n    = 1'b0;
    e_start    = 1'b0;
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % N_REQ;
    m_owner = -1;
    e_grant = '0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_edge();
    e_done  = '0;
    e_start = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner          = first_from(req, m_ptr);
        m_clr_left       = RST_CYCLES;
        e_grant          = '0;
        e_grant[m_owner] = 1'b1;
      end
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (!m_running) begin
      if (!req[m_owner]) begin
        release_owner();
      end else if (start[m_owner]) begin
        e_kin     = din[m_owner*DATA_W +: DATA_W];
        e_start   = 1'b1;
        m_running = 1'b1;
      end
    end else if (kdone) begin
      e_result  = kout;
      m_running = 1'b0;
      if (req[m_owner]) e_done[m_owner] = 1'b1;
      else              release_owner();
    end
    e_rst_n = !(m_owner >= 0 && m_clr_left > 0);
  endtask

  task automatic check_all();
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("busy", busy, (m_owner >= 0));
    chk("keccak_rst_n", krst_n, e_rst_n);
    chk("start_keccak", kstart, e_start);
    chk_wide("keccak_in", kin, e_kin);
    chk_wide("result", result, e_result);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_edge();
    check_all();
  endtask

  task automatic rand_wide(output logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  task automatic rand_din();
    logic [DATA_W-1:0] w;
    for (int r = 0; r < N_REQ; r++) begin
      rand_wide(w);
      din[r*DATA_W +: DATA_W] = w;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_krst", krst_n, 1'b0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_core_ready(input string tag);
    int n;
    n = 0;
    while (krst_n !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk(tag, krst_n, 1'b1);
  endtask

  task automatic run_session(input int o, input logic [N_REQ-1:0] base);
    int n;
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[o] = 1'b1;
    n = 0;
    while (grant == '0 && n < 8) begin
      cyc();
      n++;
    end
    chk("t3_grant_order", grant, oh);
    wait_core_ready("t3_core_ready");
    rand_din();
    start = oh;
    cyc();
    start = '0;
    repeat (3) cyc();
    rand_wide(kout);
    kdone = 1'b1;
    cyc();
    kdone = 1'b0;
    chk("t3_done", done, oh);
    req = base & ~oh;
    cyc();
    chk("t3_release", grant, '0);
    req = base;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = '0;
    start   = '0;
    din     = '0;
    kout    = '0;
    kdone   = 1'b0;
    model_reset();

    // reset state
    repeat (2) cyc();
    chk("reset_grant", grant, '0);
    chk("reset_krst", krst_n, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk("idle_krst_hi", krst_n, 1'b1);

    // 1: single request, clear sequence and first start
    rand_din();
    req = 3'b010;
    cyc();
    chk("t1_grant", grant, 3'b010);
    chk("t1_krst_lo1", krst_n, 1'b0);
    cyc();
    chk("t1_krst_lo2", krst_n, 1'b0);
    cyc();
    chk("t1_krst_hi", krst_n, 1'b1);
    start = 3'b010;
    cyc();
    start = '0;
    chk("t1_start", kstart, 1'b1);
    chk_wide("t1_kin", kin, din[DATA_W +: DATA_W]);
    cyc();
    chk("t1_start_pulse", kstart, 1'b0);

    // 2: completion after 24 cycles
    repeat (22) cyc();
    kout  = {50{32'hA5A5_A5A5}};
    kdone = 1'b1;
    cyc();
    kdone = 1'b0;
    chk("t2_done", done, 3'b010);
    chk_wide("t2_result", result, {50{32'hA5A5_A5A5}});
    rand_wide(kout);
    cyc();
    chk("t2_done_pulse", done, '0);
    req = '0;
    cyc();

    // 3: fairness
    do_reset();
    req = 3'b111;
    run_session(0, 3'b111);
    run_session(1, 3'b111);
    run_session(2, 3'b111);
    run_session(0, 3'b111);
    req = '0;
    do_reset();
    req = 3'b101;
    run_session(0, 3'b101);
    run_session(2, 3'b101);
    run_session(0, 3'b101);
    req = '0;

    // 4: ignored stimulus while owner=2
    do_reset();
    req = 3'b100;
    cyc();
    chk("t4_grant", grant, 3'b100);
    start = 3'b100;
    cyc();
    chk("t4_start_in_clr", kstart, 1'b0);
    start = '0;
    wait_core_ready("t4_core_ready");
    start = 3'b001;
    cyc();
    chk("t4_nonowner_start", kstart, 1'b0);
    start = '0;
    kdone = 1'b1;
    cyc();
    kdone = 1'b0;
    chk("t4_done_in_ready", done, '0);
    chk("t4_busy", busy, 1'b1);
    rand_din();
    start = 3'b100;
    cyc();
    chk("t4_start", kstart, 1'b1);
    cyc();
    chk("t4_start_in_run", kstart, 1'b0);
    start = '0;
    repeat (2) cyc();
    kdone = 1'b1;
    cyc();
    kdone = 1'b0;
    chk("t4_done", done, 3'b100);
    req = '0;
    cyc();
    chk("t4_release", grant, '0);

    // 5: owner drops request mid-permutation
    req = 3'b010;
    cyc();
    wait_core_ready("t5_core_ready");
    start = 3'b010;
    cyc();
    start = '0;
    repeat (3) cyc();
    req = 3'b100;
    repeat (2) cyc();
    chk("t5_no_preempt", grant, 3'b010);
    rand_wide(kout);
    kdone = 1'b1;
    cyc();
    kdone = 1'b0;
    chk("t5_done_suppressed", done, '0);
    chk_wide("t5_result", result, kout);
    chk("t5_idle", busy, 1'b0);
    cyc();
    chk("t5_next_grant", grant, 3'b100);

    // 6: reset during RUN, then a fresh session
    wait_core_ready("t6_core_ready");
    start = 3'b100;
    cyc();
    start = '0;
    repeat (3) cyc();
    do_reset();
    req = 3'b001;
    cyc();
    chk("t6_grant", grant, 3'b001);
    chk("t6_krst_lo", krst_n, 1'b0);
    cyc();
    cyc();
    chk("t6_krst_hi", krst_n, 1'b1);
    req = '0;
    cyc();

    // randomized traffic against the model
    repeat (600) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
        start[i] = ($urandom_range(0, 2) == 0);
      end
      kdone = ($urandom_range(0, 4) == 0);
      rand_wide(kout);
      rand_din();
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
